// File: rtl/mult4_pkg.sv
// Shared definitions for the mult4_seq sequential 4x4 multiplier:
// operand/product widths, FSM state encoding, shifter control codes and
// the per-step shift-code lookup.
package mult4_pkg;

  localparam int unsigned OP_W   = 4;  // operand width
  localparam int unsigned HALF_W = 2;  // operand half (digit) width
  localparam int unsigned PP_W   = 4;  // 2x2 partial product width
  localparam int unsigned PROD_W = 8;  // accumulated product width
  localparam int unsigned K_W    = 2;  // step counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SHIFT_0 = 2'b00,
    SHIFT_2 = 2'b01,
    SHIFT_4 = 2'b10
  } shift_t;

  // Weight of each step's partial product: lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic shift_t shift_code(input logic [K_W-1:0] k);
    case (k)
      2'd0:    return SHIFT_0;
      2'd3:    return SHIFT_4;
      default: return SHIFT_2;
    endcase
  endfunction

endpackage

// File: rtl/mult2x2.sv
// Combinational 2-bit x 2-bit unsigned multiplier.
//   a, b : 2-bit unsigned operands
//   p    : 4-bit unsigned product (max 9)
module mult2x2
  import mult4_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [PP_W-1:0]   p
);

  assign p = PP_W'(a) * PP_W'(b);

endmodule

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned multiplier built from one 2x2 multiplier and an
// external shifter. Four CALC steps each present one 2x2 partial product to
// the shifter and accumulate the shifted value it returns in the same cycle.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : begin a multiply (accepted in IDLE/DONE only)
//   dataa, datab : 4-bit unsigned operands, latched on an accepted start
//   shift_inp    : partial product to the shifter (0 outside CALC)
//   shift_cntrl  : shifter control 00/01/10 = shift 0/2/4 (00 outside CALC)
//   shift_out    : shifted partial product from the shifter
//   product      : accumulator (partial sums during CALC)
//   busy         : high in every CALC cycle
//   done         : one-cycle pulse on the cycle after the last accumulate
//   start_err    : only with MULT4_SEQ_START_ERR_EN defined; sticky flag for
//                  a start seen during CALC, cleared by reset or next start
module mult4_seq
  import mult4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   dataa,
  input  logic [OP_W-1:0]   datab,
  input  logic [PROD_W-1:0] shift_out,
  output logic [PP_W-1:0]   shift_inp,
  output logic [1:0]        shift_cntrl,
  output logic [PROD_W-1:0] product,
  output logic              busy,
`ifdef MULT4_SEQ_START_ERR_EN
  output logic              done,
  output logic              start_err
`else
  output logic              done
`endif
);

  state_t              state_q, state_n;
  logic [K_W-1:0]      k_q, k_n;
  logic [OP_W-1:0]     a_q, a_n, b_q, b_n;
  logic [PROD_W-1:0]   acc_q, acc_n;
  logic [HALF_W-1:0]   pp_a, pp_b;
  logic [PP_W-1:0]     pp;
`ifdef MULT4_SEQ_START_ERR_EN
  logic                err_n;
`endif

  // Next-state, operand latch and accumulator update.
  always_comb begin
    state_n = state_q;
    k_n     = k_q;
    a_n     = a_q;
    b_n     = b_q;
    acc_n   = acc_q;
`ifdef MULT4_SEQ_START_ERR_EN
    err_n   = start_err;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_n = CALC;
          k_n     = '0;
          a_n     = dataa;
          b_n     = datab;
          acc_n   = '0;
`ifdef MULT4_SEQ_START_ERR_EN
          err_n   = 1'b0;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        acc_n = acc_q + shift_out;
        k_n   = k_q + K_W'(1);
        if (k_q == K_W'(3)) state_n = DONE;
`ifdef MULT4_SEQ_START_ERR_EN
        if (start) err_n = 1'b1;
`endif
      end
      default: begin
        state_n = IDLE;
        k_n     = '0;
      end
    endcase
  end

  // Operand digits for the step that will be active next cycle, so the
  // shifter-facing outputs can be registered.
  always_comb begin
    pp_a = k_n[0] ? a_n[3:2] : a_n[1:0];
    pp_b = k_n[1] ? b_n[3:2] : b_n[1:0];
  end

  mult2x2 u_mult2x2 (
    .a (pp_a),
    .b (pp_b),
    .p (pp)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      shift_inp   <= '0;
      shift_cntrl <= SHIFT_0;
`ifdef MULT4_SEQ_START_ERR_EN
      start_err   <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      k_q         <= k_n;
      a_q         <= a_n;
      b_q         <= b_n;
      acc_q       <= acc_n;
      busy        <= (state_n == CALC);
      done        <= (state_n == DONE);
      shift_inp   <= (state_n == CALC) ? pp : '0;
      shift_cntrl <= (state_n == CALC) ? shift_code(k_n) : SHIFT_0;
`ifdef MULT4_SEQ_START_ERR_EN
      start_err   <= err_n;
`endif
    end
  end

  assign product = acc_q;

endmodule

// File: tb/tb_mult4_seq.sv
// Self-checking bench for mult4_seq with a behavioural shifter and a
// closed-form arithmetic reference for partial products and partial sums.
module tb_mult4_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dataa, datab;
  logic [3:0] shift_inp;
  logic [1:0] shift_cntrl;
  logic [7:0] shift_out;
  logic [7:0] product;
  logic       busy, done;
`ifdef MULT4_SEQ_START_ERR_EN
  logic       start_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External shifter: combinational left shift by 0/2/4.
  always_comb begin
    case (shift_cntrl)
      2'b01:   shift_out = {4'b0, shift_inp} << 2;
      2'b10:   shift_out = {4'b0, shift_inp} << 4;
      default: shift_out = {4'b0, shift_inp};
    endcase
  end

  mult4_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
    .shift_out   (shift_out),
    .shift_inp   (shift_inp),
    .shift_cntrl (shift_cntrl),
    .product     (product),
    .busy        (busy),
`ifdef MULT4_SEQ_START_ERR_EN
    .done        (done),
    .start_err   (start_err)
`else
    .done        (done)
`endif
  );

  // Partial product presented at step k (lo/hi digit table).
  function automatic int exp_pp(input int a, input int b, input int k);
    int ad, bd;
    ad = (k % 2 == 1) ? a / 4 : a % 4;
    bd = (k >= 2)     ? b / 4 : b % 4;
    return ad * bd;
  endfunction

  function automatic int exp_cntrl(input int k);
    return (k == 0) ? 0 : (k == 3) ? 2 : 1;
  endfunction

  // Accumulator value after n accumulate edges, in closed form.
  function automatic int exp_sum(input int a, input int b, input int n);
    case (n)
      0:       return 0;
      1:       return (a % 4) * (b % 4);
      2:       return a * (b % 4);
      3:       return a * (b % 4) + 4 * (a % 4) * (b / 4);
      default: return a * b;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dataa = 4'd0; datab = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, product, shift_inp, shift_cntrl} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b product=%0d inp=%0d cntrl=%b, want all 0",
               busy, done, product, shift_inp, shift_cntrl);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, product} !== 10'd0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b product=%0d, want 0", busy, done, product);
    end
  endtask

  // One full multiply with cycle-by-cycle checks from E0 to E5.
  task automatic test_mult(input int a, input int b);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL pre_busy %0dx%0d: got busy=%b, want 0", a, b, busy);
    end
    start = 1'b1; dataa = 4'(a); datab = 4'(b);
    @(negedge clk);
    start = 1'b0; dataa = 4'($urandom); datab = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || shift_inp !== 4'(exp_pp(a, b, k)) ||
          shift_cntrl !== 2'(exp_cntrl(k)) || product !== 8'(exp_sum(a, b, k))) begin
        errors++;
        $display("FAIL calc %0dx%0d k=%0d: got busy=%b done=%b inp=%0d cntrl=%b product=%0d, want 1 0 %0d %0d %0d",
                 a, b, k, busy, done, shift_inp, shift_cntrl, product,
                 exp_pp(a, b, k), exp_cntrl(k), exp_sum(a, b, k));
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== 8'(a * b) ||
        shift_inp !== 4'd0 || shift_cntrl !== 2'd0) begin
      errors++;
      $display("FAIL done %0dx%0d: got done=%b busy=%b product=%0d inp=%0d cntrl=%b, want 1 0 %0d 0 0",
               a, b, done, busy, product, shift_inp, shift_cntrl, a * b);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || product !== 8'(a * b)) begin
      errors++;
      $display("FAIL hold %0dx%0d: got done=%b product=%0d, want 0 %0d", a, b, done, product, a * b);
    end
  endtask

  task automatic test_corners();
    test_mult(15, 15);
    test_mult(3, 5);
    test_mult(0, 9);
    test_mult(15, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) test_mult(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endtask

  // Start during CALC is ignored; start in DONE restarts immediately.
  task automatic test_start_ignored();
    @(negedge clk);
    start = 1'b1; dataa = 4'd7; datab = 4'd2;
    @(negedge clk);                          // k0
    dataa = 4'd15; datab = 4'd15;
    @(negedge clk);                          // k1
    dataa = 4'd1; datab = 4'd1;
    @(negedge clk);                          // k2
    start = 1'b0; dataa = 4'd9;
    @(negedge clk);                          // k3
    @(negedge clk);                          // DONE
    checks++;
    if (done !== 1'b1 || product !== 8'd14) begin
      errors++;
      $display("FAIL ignore_start: got done=%b product=%0d, want 1 14", done, product);
    end
`ifdef MULT4_SEQ_START_ERR_EN
    checks++;
    if (start_err !== 1'b1) begin
      errors++;
      $display("FAIL start_err_set: got %b, want 1", start_err);
    end
`endif
    start = 1'b1; dataa = 4'd2; datab = 4'd6;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== 8'd0 || shift_inp !== 4'(exp_pp(2, 6, 0))) begin
      errors++;
      $display("FAIL restart: got busy=%b done=%b product=%0d inp=%0d, want 1 0 0 %0d",
               busy, done, product, shift_inp, exp_pp(2, 6, 0));
    end
`ifdef MULT4_SEQ_START_ERR_EN
    checks++;
    if (start_err !== 1'b0) begin
      errors++;
      $display("FAIL start_err_clear: got %b, want 0", start_err);
    end
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || product !== 8'd12) begin
      errors++;
      $display("FAIL restart_result: got done=%b product=%0d, want 1 12", done, product);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of CALC.
  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; dataa = 4'd15; datab = 4'd15;
    @(negedge clk);                          // k0
    start = 1'b0;
    @(negedge clk);                          // k1
    @(negedge clk);                          // k2
    checks++;
    if (busy !== 1'b1 || product !== 8'd45) begin
      errors++;
      $display("FAIL pre_reset: got busy=%b product=%0d, want 1 45", busy, product);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, product, shift_inp, shift_cntrl} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b product=%0d inp=%0d cntrl=%b, want all 0",
               busy, done, product, shift_inp, shift_cntrl);
    end
`ifdef MULT4_SEQ_START_ERR_EN
    checks++;
    if (start_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_err: got %b, want 0", start_err);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 8'd0) begin
        errors++;
        $display("FAIL post_reset cyc=%0d: got done=%b busy=%b product=%0d, want 0 0 0",
                 i, done, busy, product);
      end
      @(negedge clk);
    end
    test_mult(4, 4);
  endtask

  initial begin
    test_reset();
    test_corners();
    test_random();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult4_seq.md
MULT4_SEQ -- requirements
Module: mult4_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port start, input, 1; request to multiply dataa by datab.
REQ-004 SHALL have ports dataa and datab, input, 4 each; unsigned operands, sampled only when start is accepted.
REQ-005 SHALL have port shift_inp, output, 4; 2x2 partial product driven to the downstream shifter's data input.
REQ-006 SHALL have port shift_cntrl, output, 2; shifter control: 00 = no shift, 01 = shift by 2, 10 = shift by 4.
REQ-007 SHALL have port shift_out, input, 8; shifted partial product returned combinationally by the shifter in the same cycle.
REQ-008 SHALL have port product, output, 8; accumulated result.
REQ-009 SHALL have port busy, output, 1; high in every CALC cycle.
REQ-010 SHALL have port done, output, 1; single-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE; CALC uses a 2-bit step counter k = 0..3.
REQ-012 In IDLE or DONE, start=1 SHALL latch dataa/datab, clear the accumulator, set k=0 and enter CALC.
REQ-013 In CALC, start SHALL be ignored and the latched operands SHALL NOT change.
REQ-014 Per k, SHALL drive shift_inp/shift_cntrl as: k0 = a[1:0]*b[1:0] with 00; k1 = a[3:2]*b[1:0] with 01; k2 = a[1:0]*b[3:2] with 01; k3 = a[3:2]*b[3:2] with 10.
REQ-015 Each CALC cycle SHALL perform acc <= acc + shift_out (8-bit, modulo 256); wrap cannot occur because the maximum product is 225.
REQ-016 After the k=3 accumulate edge, SHALL enter DONE; done=1 for exactly that one cycle.
REQ-017 DONE SHALL go to IDLE next cycle unless start=1 (then REQ-012 applies).
REQ-018 Latency SHALL be: start accepted at edge E0, accumulates at E1..E4, done high from E4 to E5.
REQ-019 product SHALL equal the accumulator at all times, hold its final value in IDLE/DONE, and show partial sums during CALC.
REQ-020 Outside CALC, shift_inp SHALL be 0 and shift_cntrl SHALL be 00.

Reset
REQ-021 Asserting reset SHALL immediately force state=IDLE, k=0, acc/product=0, latched operands=0, busy=0, done=0, shift_inp=0, shift_cntrl=00, including mid-CALC; no done pulse follows.
REQ-022 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-023 With macro MULT4_SEQ_START_ERR_EN defined, SHALL add output start_err (1 bit): set to 1 when start=1 in a CALC cycle, cleared only by reset or an accepted start; without the macro, the port and its logic SHALL be absent.

Structure
REQ-024 SHALL place the state encoding (IDLE/CALC/DONE) and shift codes (SHIFT_0=00, SHIFT_2=01, SHIFT_4=10) in shared package mult4_pkg.
REQ-025 SHALL instantiate one combinational sub-module, mult2x2 (2-bit by 2-bit to 4-bit unsigned); the shifter remains external, connected through shift_inp, shift_cntrl and shift_out.

Verification (bench instantiates mult4_seq and the shifter)
REQ-026 dataa=15, datab=15, pulse start -> shift_inp 9,9,9,9 with cntrl 00,01,01,10; product 225; done one cycle at E4.
REQ-027 dataa=3, datab=5 -> partial sums 3,3,15,15; product=15; busy high exactly 4 cycles.
REQ-028 dataa=0, datab=9 -> product=0, done still pulses at E4.
REQ-029 start held high with dataa=7, datab=2 mid-CALC, then operands changed -> result 14 unaffected; start in the DONE cycle with 2x6 -> immediate restart, product=12; with macro: start_err=1 after the mid-CALC start, cleared by the next accepted start.
REQ-030 reset asserted at k=2 of 15x15 -> all outputs 0 asynchronously, no done; next 4x4 -> 16.
